// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input combinations of a 3-input logic block and reassembles
// the 8-bit truth-table code it implements, with match and per-combination stability.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       match,
  output logic [7:0] unstable
);

  localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    exp_reg;
  logic [7:0]    code_reg;
  logic [7:0]    unstable_reg;
  logic          ref_reg;
  logic          match_valid_reg;

  logic running;
  logic accept;
  logic cancel;
  logic settle_end;
  logic sample_end;
  logic last_comb;

  assign running    = (state_reg == SETTLE) || (state_reg == SAMPLE);
  assign accept     = (state_reg == IDLE) && start;
  assign cancel     = running && abort;
  assign settle_end = (cnt_reg == SETTLE_LAST);
  assign sample_end = (cnt_reg == HOLD_LAST);
  assign last_comb  = (idx_reg == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE: begin
        if (abort)           state_next = IDLE;
        else if (settle_end) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (abort)           state_next = IDLE;
        else if (sample_end) state_next = last_comb ? DONE : SETTLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change, so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (running) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg         <= 3'd0;
      exp_reg         <= 8'h00;
      code_reg        <= 8'h00;
      unstable_reg    <= 8'h00;
      ref_reg         <= 1'b0;
      match_valid_reg <= 1'b0;
    end else if (accept) begin
      idx_reg         <= 3'd0;
      exp_reg         <= expected;
      code_reg        <= 8'h00;
      unstable_reg    <= 8'h00;
      match_valid_reg <= 1'b0;
    end else if (cancel) begin
      idx_reg         <= 3'd0;
      match_valid_reg <= 1'b0;
    end else if (state_reg == SAMPLE) begin
      // First hold cycle captures the reference; later cycles only flag changes.
      if (cnt_reg == '0) begin
        code_reg[3'd7 - idx_reg] <= dut_out;
        ref_reg                  <= dut_out;
      end else if (dut_out != ref_reg) begin
        unstable_reg[3'd7 - idx_reg] <= 1'b1;
      end
      if (sample_end) begin
        idx_reg <= last_comb ? 3'd0 : idx_reg + 3'd1;
        if (last_comb) match_valid_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    {in1, in2, in3} = idx_reg;
    busy            = running;
    done            = (state_reg == DONE);
    code            = code_reg;
    unstable        = unstable_reg;
    match           = match_valid_reg && (code_reg == exp_reg);
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: a timeline model predicts every
// output cycle by cycle from the per-cycle values the bench feeds to dut_out.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       dut_out = 1'b0;
  logic       sel = 1'b0;

  logic       in1_a, in2_a, in3_a, busy_a, done_a, match_a;
  logic [7:0] code_a, unst_a;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, match_b;
  logic [7:0] code_b, unst_b;

  always #5 clk = ~clk;

  truth_table_sweeper dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .expected(expected), .dut_out(dut_out),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
    .code(code_a), .match(match_a), .unstable(unst_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .expected(expected), .dut_out(dut_out),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
    .code(code_b), .match(match_b), .unstable(unst_b)
  );

  wire [2:0] d_in    = sel ? {in1_b, in2_b, in3_b} : {in1_a, in2_a, in3_a};
  wire       d_busy  = sel ? busy_b  : busy_a;
  wire       d_done  = sel ? done_b  : done_a;
  wire       d_match = sel ? match_b : match_a;
  wire [7:0] d_code  = sel ? code_b  : code_a;
  wire [7:0] d_unst  = sel ? unst_b  : unst_a;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: active sweep, cycle index j since the accepting edge.
  int S = 4, H = 2, P = 6;
  bit         active = 0;
  int         j = 0;
  logic [7:0] m_code = 0, m_unst = 0, m_exp = 0;
  logic       m_match = 0;
  logic       val [0:7][0:5];

  task automatic chk(string name, int act, int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-combination dut_out timeline: noise in settle, truth bit at first hold,
  // optional disturbances in later hold cycles.
  task automatic gen_sweep(logic [7:0] truth, int gm);
    for (int c = 0; c < 8; c++)
      for (int p = 0; p < P; p++) begin
        if (p < S)       val[c][p] = 1'($urandom);
        else if (p == S) val[c][p] = truth[7-c];
        else if (gm == 1) val[c][p] = truth[7-c] ^ ($urandom % 3 == 0);
        else if (gm == 2) val[c][p] = truth[7-c] ^ (c == 5 && p == S + 1);
        else             val[c][p] = truth[7-c];
      end
  endtask

  task automatic model_step();
    int c, p;
    if (rst) begin
      active = 0; j = 0; m_code = 0; m_unst = 0; m_match = 0;
    end else if (active) begin
      if (j < 8 * P) begin
        if (abort) active = 0;
        else begin
          c = j / P; p = j % P;
          if (p == S) m_code[7-c] = val[c][p];
          else if (p > S && val[c][p] != val[c][S]) m_unst[7-c] = 1'b1;
          j++;
          if (j == 8 * P) m_match = (m_code == m_exp);
        end
      end else active = 0;
    end else if (start) begin
      active = 1; j = 0; m_code = 0; m_unst = 0; m_match = 0; m_exp = expected;
    end
  endtask

  task automatic compare_all();
    bit eb;
    eb = active && (j < 8 * P);
    chk("busy", d_busy, eb);
    chk("done", d_done, active && (j == 8 * P));
    chk("in", d_in, eb ? j / P : 0);
    chk("code", d_code, m_code);
    chk("unstable", d_unst, m_unst);
    chk("match", d_match, m_match);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (active && j < 8 * P) dut_out = val[j/P][j%P];
    else dut_out = 1'($urandom);
  endtask

  task automatic set_sel(logic v);
    if (v != sel) begin
      rst = 1; cycle(); rst = 0;
      sel = v;
      S = v ? 1 : 4; H = v ? 1 : 2; P = S + H;
    end
  endtask

  task automatic start_sweep(logic [7:0] truth, logic [7:0] expv, int gm, bit rnd_abort);
    gen_sweep(truth, gm);
    start = 1; expected = expv; abort = rnd_abort ? 1'($urandom) : 1'b0;
    cycle();
    start = 0; abort = 0; expected = 8'($urandom);
  endtask

  // n = cycles from the start cycle through the first cycle with done high.
  task automatic wait_done(output int n);
    n = 1;
    while (!d_done && n < 200) begin cycle(); n++; end
    chk("done_timeout", d_done, 1);
  endtask

  initial begin
    int n;
    logic [7:0] truth, expv;

    repeat (3) cycle();
    rst = 0;
    chk("reset_code", d_code, 8'h00);
    chk("reset_in", d_in, 0);
    cycle();

    // Basic 0xF6 sweep, matching expectation.
    start_sweep(8'hF6, 8'hF6, 0, 0);
    wait_done(n);
    chk("lat_f6", n, 49);
    chk("code_f6", d_code, 8'hF6);
    chk("match_f6", d_match, 1);
    chk("unst_f6", d_unst, 8'h00);
    $display("sweep truth=f6 exp=f6 latency=%0d code=%02h match=%0d", n, d_code, d_match);
    repeat (2) cycle();

    start_sweep(8'hF6, 8'hF7, 0, 0);
    wait_done(n);
    chk("lat_f7", n, 49);
    chk("code_f7", d_code, 8'hF6);
    chk("match_f7", d_match, 0);
    $display("sweep truth=f6 exp=f7 latency=%0d code=%02h match=%0d", n, d_code, d_match);
    cycle();

    start_sweep(8'hF6, 8'hF6, 2, 0);
    wait_done(n);
    chk("glitch_unst", d_unst, 8'h04);
    chk("glitch_code", d_code, 8'hF6);
    $display("sweep glitch on 101 code=%02h unstable=%02h", d_code, d_unst);
    cycle();

    // Abort during combination 011 settle.
    start_sweep(8'hF6, 8'hF6, 0, 0);
    while (j != 3 * P + 1 && active) cycle();
    abort = 1; cycle(); abort = 0;
    chk("abort_busy", d_busy, 0);
    chk("abort_in", d_in, 0);
    chk("abort_code", d_code, 8'hE0);
    repeat (60) cycle();
    $display("abort in comb 011 partial code=%02h", d_code);
    start_sweep(8'h3C, 8'h3C, 0, 0);
    wait_done(n);
    chk("after_abort_code", d_code, 8'h3C);
    chk("after_abort_match", d_match, 1);
    cycle();

    // Start re-pulsed during a running sweep is ignored.
    start_sweep(8'hF6, 8'hF6, 0, 0);
    n = 1;
    while (!d_done && n < 200) begin
      start = (n == 10 || n == 30);
      cycle(); start = 0; n++;
    end
    chk("repulse_lat", n, 49);
    $display("sweep with start re-pulses latency=%0d", n);
    cycle();

    // Asynchronous reset mid-SAMPLE.
    start_sweep(8'hF6, 8'hF6, 0, 0);
    while (j != 2 * P + S && active) cycle();
    #2 rst = 1;
    #1;
    chk("arst_code", d_code, 8'h00);
    chk("arst_busy", d_busy, 0);
    chk("arst_in", d_in, 0);
    chk("arst_unst", d_unst, 8'h00);
    cycle();
    rst = 0;
    cycle();
    set_sel(1);
    start_sweep(8'h96, 8'h96, 0, 0);
    wait_done(n);
    chk("fast_lat", n, 17);
    chk("fast_code", d_code, 8'h96);
    chk("fast_match", d_match, 1);
    $display("fast sweep truth=96 latency=%0d code=%02h", n, d_code);
    cycle();

    // Randomized sweeps on both configurations.
    for (int s = 0; s < 40; s++) begin
      set_sel(1'($urandom % 4 == 0));
      truth = 8'($urandom);
      expv  = ($urandom % 2 != 0) ? truth : 8'($urandom);
      start_sweep(truth, expv, 1, 1);
      n = 0;
      while (active && n < 300) begin
        start = ($urandom % 10 == 0);
        abort = (j < 8 * P) && (j % P < S) && ($urandom % 60 == 0);
        cycle(); start = 0; abort = 0; n++;
      end
      chk("rand_timeout", active, 0);
      $display("rand sweep %0d sel=%0d truth=%02h exp=%02h code=%02h unstable=%02h match=%0d",
               s, sel, truth, expv, d_code, d_unst, d_match);
      repeat ($urandom_range(1, 3)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
